// File: rtl/bcd_cnt_pkg.sv
// Shared constants and helpers for the BCD up/down counter.
// Segment patterns, BCD limits, mode encodings, decode/saturate helpers.
package bcd_cnt_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        MODE_UP = 1'b0,
        MODE_DN = 1'b1
    } updn_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: next value and carry/borrow out for a single digit.
// Ports: digit (current), en (carry/borrow in), up_dn, nxt, co.
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       en,
    input  logic       up_dn,
    output logic [3:0] nxt,
    output logic       co
);

    always_comb begin
        nxt = digit;
        co  = 1'b0;
        if (en) begin
            if (updn_e'(up_dn) == MODE_DN) begin
                if (digit == BCD_MIN) begin
                    nxt = BCD_MAX;
                    co  = 1'b1;
                end else begin
                    nxt = digit - 4'd1;
                end
            end else begin
                if (digit >= BCD_MAX) begin
                    nxt = BCD_MIN;
                    co  = 1'b1;
                end else begin
                    nxt = digit + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updn_counter_n.sv
// N-digit BCD up/down push counter with synchroniser and debouncer.
// In: i_Clk, i_Rst, i_Push, i_UpDnMode, i_Clr, i_Load, i_LoadVal.
// Out: o_Bcd, o_FND (active-low segments), o_Carry (wrap pulse), o_Zero.
module bcd_updn_counter_n
    import bcd_cnt_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Push,
    input  logic                    i_UpDnMode,
    input  logic                    i_Clr,
    input  logic                    i_Load,
    input  logic [4*NUM_DIGITS-1:0] i_LoadVal,
    output logic [4*NUM_DIGITS-1:0] o_Bcd,
    output logic [7*NUM_DIGITS-1:0] o_FND,
    output logic                    o_Carry,
    output logic                    o_Zero
);

    localparam int DW =
        (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 1);

    logic          s1;
    logic          s2;
    logic          stb;
    logic [DW-1:0] dcnt;
    logic          accept;
    logic          press;

    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [4*NUM_DIGITS-1:0] bcd_cnt;
    logic [4*NUM_DIGITS-1:0] bcd_ld;
    logic [NUM_DIGITS:0]     chain;
    logic                    carry_q;

    // stb is about to change; a press is the 1 -> 0 change only
    assign accept = (s2 != stb) && (dcnt == DCNT_LAST);
    assign press  = accept && stb;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            stb  <= 1'b1;
            dcnt <= '0;
        end else begin
            s1 <= i_Push;
            s2 <= s1;
            if (s2 == stb) begin
                dcnt <= '0;
            end else if (dcnt == DCNT_LAST) begin
                stb  <= s2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    // Digit 0 always steps on a count; higher digits step on ripple
    assign chain[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit (bcd_q[4*g +: 4]),
            .en    (chain[g]),
            .up_dn (i_UpDnMode),
            .nxt   (bcd_cnt[4*g +: 4]),
            .co    (chain[g+1])
        );
        assign bcd_ld[4*g +: 4] = bcd_sat(i_LoadVal[4*g +: 4]);
        assign o_FND[7*g +: 7]  = seg_decode(bcd_q[4*g +: 4]);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            bcd_q   <= '0;
            carry_q <= 1'b0;
        end else if (i_Clr) begin
            bcd_q   <= '0;
            carry_q <= 1'b0;
        end else if (i_Load) begin
            bcd_q   <= bcd_ld;
            carry_q <= 1'b0;
        end else if (press) begin
            bcd_q   <= bcd_cnt;
            carry_q <= chain[NUM_DIGITS];
        end else begin
            carry_q <= 1'b0;
        end
    end

    assign o_Bcd   = bcd_q;
    assign o_Carry = carry_q;
    assign o_Zero  = (bcd_q == '0);

endmodule
